// File: rtl/online_defs.sv
// Shared definitions for the online-operator datapath: signed-digit encodings,
// converter FSM state encodings and the default word length in digits.
// Pure declarations; no logic.
package online_defs;

  // Digits per word: 8 adder stages plus the carry digit.
  localparam int NDIG_DEFAULT = 9;

  // Borrow-save digit {p,n}; value = p - n. Both zero encodings mean 0.
  localparam logic [1:0] SD_POS      = 2'b10;
  localparam logic [1:0] SD_ZERO     = 2'b00;
  localparam logic [1:0] SD_NEG      = 2'b01;
  localparam logic [1:0] SD_ZERO_ALT = 2'b11;

  // Converter FSM: ACC assembles a word, HOLD presents the finished word.
  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/otf_digit_step.sv
// One on-the-fly conversion step: appends a signed digit to the prefix pair (Q, Q-1).
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is registered.
module otf_digit_step
  import online_defs::*;
#(
  parameter int OW = 10
) (
  input  logic [OW-1:0] q,
  input  logic [OW-1:0] qm,
  input  logic [1:0]    digit,
  output logic [OW-1:0] q_next,
  output logic [OW-1:0] qm_next
);

  // Select the shifted source for each register so no carry chain is ever needed:
  // a +1 digit builds from Q, a -1 digit borrows from QM, a 0 digit keeps both.
  always_comb begin
    q_next  = {q[OW-2:0], 1'b0};
    qm_next = {qm[OW-2:0], 1'b1};
    case (digit)
      SD_POS: begin
        q_next  = {q[OW-2:0], 1'b1};
        qm_next = {q[OW-2:0], 1'b0};
      end
      SD_NEG: begin
        q_next  = {qm[OW-2:0], 1'b1};
        qm_next = {qm[OW-2:0], 1'b0};
      end
      default: begin
        q_next  = {q[OW-2:0], 1'b0};
        qm_next = {qm[OW-2:0], 1'b1};
      end
    endcase
  end

endmodule

// File: rtl/sd_to_binary_converter.sv
// MSB-first signed-digit to two's-complement converter, one digit per accepted handshake.
// Latency: word valid the cycle after its last digit is accepted; one word per NDIG cycles.
// Backpressure: a held word blocks input until out_ready; a digit may be taken in the release cycle.
module sd_to_binary_converter
  import online_defs::*;
#(
  parameter int NDIG = NDIG_DEFAULT
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_digit,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [NDIG:0] out_data,
  output logic          busy
);

  localparam int OW = NDIG + 1;
  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [OW-1:0] q;
  logic [OW-1:0] qm;
  logic [OW-1:0] q_step;
  logic [OW-1:0] qm_step;
  logic          accept;
  logic          last;

  // clr outranks every handshake, so a digit offered alongside it is never taken.
  assign accept = in_valid & in_ready & ~clr;
  assign last   = accept & (cnt == LAST_CNT);

  otf_digit_step #(
    .OW(OW)
  ) u_step (
    .q      (q),
    .qm     (qm),
    .digit  (in_digit),
    .q_next (q_step),
    .qm_next(qm_step)
  );

  // State register.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state <= ST_ACC;
    end else begin
      state <= state_next;
    end
  end

  // Next state: finish a word into HOLD, leave HOLD when the sink takes it.
  always_comb begin
    state_next = state;
    if (clr) begin
      state_next = ST_ACC;
    end else if (last) begin
      state_next = ST_HOLD;
    end else if ((state == ST_HOLD) && out_ready) begin
      state_next = ST_ACC;
    end
  end

  // Handshake outputs; input stays open in HOLD whenever the sink is draining this cycle.
  always_comb begin
    in_ready  = (state == ST_ACC) | out_ready;
    out_valid = (state == ST_HOLD);
    busy      = (cnt != '0);
  end

  // Digit position counter; wraps to zero on the final digit of each word.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (last) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Prefix pair; re-seeded to 0/-1 after each word so a digit taken in HOLD starts fresh.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      q  <= '0;
      qm <= '1;
    end else if (clr || last) begin
      q  <= '0;
      qm <= '1;
    end else if (accept) begin
      q  <= q_step;
      qm <= qm_step;
    end
  end

  // Result register: loaded only when a word completes, so it stays stable through HOLD.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      out_data <= '0;
    end else if (last) begin
      out_data <= q_step;
    end
  end

endmodule

// File: tb/tb_sd_to_binary_converter.sv
// Scoreboard bench for sd_to_binary_converter: words are valued as sum d_i*2^(NDIG-1-i)
// by the driver, queued, and compared by an independent monitor at each output handshake.
module tb_sd_to_binary_converter;

  localparam int NDIG = 9;
  localparam int OW   = NDIG + 1;

  logic          clk = 1'b0;
  logic          Reset;
  logic          clr;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_digit;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          busy;

  always #5 clk = ~clk;

  sd_to_binary_converter #(.NDIG(NDIG)) dut (
    .clk      (clk),
    .Reset    (Reset),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_digit (in_digit),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [OW-1:0] exp_q[$];
  int            stim_q[$];
  int            gap_pct  = 0;
  int            alt_mode = 0;   // 0: zero as 2'b00, 1: zero as 2'b11, 2: random
  int            ready_mode = 0; // 0: always ready, 1: random, 2: stall 3 cycles per word
  int            hcnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] enc(input int d, input int mode);
    if (d > 0) return 2'b10;
    if (d < 0) return 2'b01;
    if (mode == 1) return 2'b11;
    if (mode == 2) return ($urandom_range(1) == 1) ? 2'b11 : 2'b00;
    return 2'b00;
  endfunction

  task automatic add_word(input int w[NDIG]);
    for (int i = 0; i < NDIG; i++) stim_q.push_back(w[i]);
  endtask

  // Drives queued digits; reference value is plain positional arithmetic on accepted digits.
  task automatic run_stim(input bit push);
    int  val;
    int  n;
    int  d;
    int  waitc;
    bit  done;
    logic [31:0] v;
    val = 0;
    n   = 0;
    while (stim_q.size() > 0) begin
      d     = stim_q.pop_front();
      waitc = 0;
      done  = 1'b0;
      while (!done) begin
        @(posedge clk); #1;
        in_valid = ($urandom_range(99) >= gap_pct);
        in_digit = enc(d, alt_mode);
        @(negedge clk);
        if (in_valid && in_ready) begin
          done = 1'b1;
        end else if (++waitc > 1000) begin
          n_checks++;
          n_fail++;
          $display("FAIL accept_timeout: digit not accepted after %0d cycles", waitc);
          stim_q.delete();
          in_valid = 1'b0;
          return;
        end
      end
      val = val * 2 + d;
      n++;
      if (n == NDIG) begin
        v = val;
        if (push) exp_q.push_back(v[OW-1:0]);
        val = 0;
        n   = 0;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (exp_q.size() > 0 && c < 300) begin
      @(negedge clk);
      c++;
    end
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic random_words(input int count);
    for (int k = 0; k < count; k++)
      for (int i = 0; i < NDIG; i++) stim_q.push_back(int'($urandom_range(2)) - 1);
  endtask

  // Sink: ready policy chosen per test phase.
  always begin
    @(posedge clk); #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(3) != 0);
      default: begin
        if (out_valid && hcnt < 3) begin
          out_ready = 1'b0;
          hcnt++;
        end else begin
          out_ready = 1'b1;
          if (!out_valid) hcnt = 0;
        end
      end
    endcase
  end

  // Monitor: output scoreboard, HOLD stability/backpressure, and one-cycle latency.
  int            macc = 0;
  bit            lat_pend = 1'b0;
  bit            prev_stall = 1'b0;
  logic [OW-1:0] held;
  always @(negedge clk) begin
    if (lat_pend) check("latency_out_valid", out_valid, 1);
    lat_pend = 1'b0;
    if (Reset || clr) begin
      macc = 0;
    end else if (in_valid && in_ready) begin
      if (macc == NDIG - 1) begin
        macc = 0;
        lat_pend = 1'b1;
      end else begin
        macc++;
      end
    end
    if (out_valid && prev_stall) check("hold_data_stable", out_data, held);
    if (out_valid && !out_ready) check("hold_in_ready_low", in_ready, 0);
    prev_stall = out_valid && !out_ready && !Reset && !clr;
    held = out_data;
    if (out_valid && out_ready && !Reset && !clr) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word: got %0h, expected no word", out_data);
      end else begin
        check("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    Reset     = 1'b1;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_digit  = 2'b00;
    out_ready = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    @(posedge clk);
    @(posedge clk); #1;
    Reset = 1'b0;

    // Directed words, back-to-back with the sink always ready (no bubble between words).
    add_word('{1, 0, 0, 0, 0, 0, 0, 0, 0});
    add_word('{-1, 1, 0, 0, 0, 0, 0, 0, 0});
    add_word('{-1, -1, -1, -1, -1, -1, -1, -1, -1});
    add_word('{1, 1, 1, 1, 1, 1, 1, 1, 1});
    add_word('{1, -1, -1, -1, -1, -1, -1, -1, -1});
    run_stim(1);
    drain();

    // Same zero-bearing words using the alternate zero encoding.
    alt_mode = 1;
    add_word('{1, 0, 0, 0, 0, 0, 0, 0, 0});
    add_word('{-1, 1, 0, 0, 0, 0, 0, 0, 0});
    run_stim(1);
    drain();
    alt_mode = 0;

    // Sink stalls 3 cycles in HOLD while the next word waits.
    ready_mode = 2;
    add_word('{1, 0, 1, -1, 0, 0, 1, 0, -1});
    add_word('{-1, 0, 0, 1, 1, 0, -1, 1, 0});
    run_stim(1);
    drain();
    ready_mode = 0;

    // clr after four digits drops the partial word and the digit offered with it.
    add_word('{1, 1, -1, 1, 0, 0, 0, 0, 0});
    repeat (5) void'(stim_q.pop_back());
    run_stim(0);
    check("pre_clr_busy", busy, 1);
    @(posedge clk); #1;
    clr      = 1'b1;
    in_valid = 1'b1;
    in_digit = 2'b10;
    @(posedge clk); #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("clr_busy", busy, 0);
    check("clr_out_valid", out_valid, 0);
    add_word('{1, 0, 0, 0, 0, 0, 0, 0, 0});
    run_stim(1);
    drain();

    // Asynchronous reset after four digits.
    add_word('{-1, 1, 1, -1, 0, 0, 0, 0, 0});
    repeat (5) void'(stim_q.pop_back());
    run_stim(0);
    @(posedge clk); #3;
    Reset = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 0);
    @(posedge clk); #1;
    Reset = 1'b0;
    add_word('{1, 0, 0, 0, 0, 0, 0, 0, 0});
    run_stim(1);
    drain();

    // Randomized words, input gaps, random sink backpressure and mixed zero encodings.
    ready_mode = 1;
    gap_pct    = 30;
    alt_mode   = 2;
    random_words(25);
    run_stim(1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
